// File: rtl/spi_master_cmd_if.sv
// spi_master_cmd_if: command, response and SPI pin bundle for spi_master_cmd.
// Latency: none (plain wires).
// Backpressure: cmd_valid/cmd_ready handshake; responses are unthrottled pulses.
// Ports: cmd_* request, rsp_* reply, busy status, sclk/cs_n/mosi/miso pins.
// Modports: master = the SPI master block, slave = the controller/pin side facing it.
interface spi_master_cmd_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_opcode;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        sclk;
  logic        cs_n;
  logic        mosi;
  logic        miso;

  modport master (
    input  cmd_valid, cmd_opcode, cmd_data, miso,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, busy, sclk, cs_n, mosi
  );

  modport slave (
    output cmd_valid, cmd_opcode, cmd_data, miso,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy, sclk, cs_n, mosi
  );
endinterface

// File: rtl/spi_master_cmd.sv
// spi_master_cmd: SPI mode-0 master sending {opcode, data} frames and capturing the 32-bit reply field.
// Latency: one frame; rsp_valid pulses on the clk edge that raises cs_n after the CS hold time.
// Backpressure: cmd_ready only in IDLE; cmd_valid while busy is ignored, never queued.
// Ports: clk, rst (async, active high); bus = spi_master_cmd_if.master (cmd_*, rsp_*, busy, sclk, cs_n, mosi, miso).
// Optional: define SPI_MASTER_PARITY_EN for a 41st even-parity bit on MOSI and a parity check on MISO (rsp_err).
module spi_master_cmd #(
  parameter int CLK_DIV      = 4,
  parameter int CS_SETUP_CYC = 2,
  parameter int CS_HOLD_CYC  = 2,
  parameter int CS_GAP_CYC   = 4
) (
  input  logic             clk,
  input  logic             rst,
  spi_master_cmd_if.master bus
);
`ifdef SPI_MASTER_PARITY_EN
  localparam int N_BITS = 41;
`else
  localparam int N_BITS = 40;
`endif
  // first low phase must also satisfy the SCLK half-period
  localparam int SETUP_LEN = (CS_SETUP_CYC > CLK_DIV) ? CS_SETUP_CYC : CLK_DIV;
  localparam int HOLD_LEN  = (CS_HOLD_CYC > 1) ? CS_HOLD_CYC : 1;
  localparam int GAP_LEN   = (CS_GAP_CYC > 1) ? CS_GAP_CYC : 1;
  localparam int MAX_A     = (CLK_DIV > CS_SETUP_CYC) ? CLK_DIV : CS_SETUP_CYC;
  localparam int MAX_B     = (CS_HOLD_CYC > CS_GAP_CYC) ? CS_HOLD_CYC : CS_GAP_CYC;
  localparam int MAX_CYC   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int DIV_W     = $clog2(MAX_CYC + 1);
  localparam int BIT_W     = $clog2(N_BITS + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SCLK_HI, SCLK_LO, HOLD, GAP} state_t;

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div_cnt, phase_last;
  logic [BIT_W-1:0]  bit_cnt;
  logic [N_BITS-1:0] tx_sh, frame_word;
  logic [31:0]       rx_sh;
  logic              miso_meta, miso_sync;
  logic              sclk_q, cs_n_q, mosi_q, rsp_valid_q, rsp_err_q;
  logic [31:0]       rsp_data_q;
  logic              accept, phase_done, last_bit;
  logic              load, sclk_rise, sclk_fall, frame_end;
`ifdef SPI_MASTER_PARITY_EN
  logic              rx_par;
`endif

  assign accept   = bus.cmd_valid && (state == IDLE);
  assign last_bit = (bit_cnt == BIT_W'(N_BITS - 1));

`ifdef SPI_MASTER_PARITY_EN
  assign frame_word = {bus.cmd_opcode, bus.cmd_data, ^{bus.cmd_opcode, bus.cmd_data}};
`else
  assign frame_word = {bus.cmd_opcode, bus.cmd_data};
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state: every timed phase ends when div_cnt reaches that phase's last cycle
  always_comb begin
    phase_last = '0;
    case (state)
      SETUP:            phase_last = DIV_W'(SETUP_LEN - 1);
      SCLK_HI, SCLK_LO: phase_last = DIV_W'(CLK_DIV - 1);
      HOLD:             phase_last = DIV_W'(HOLD_LEN - 1);
      GAP:              phase_last = DIV_W'(GAP_LEN - 1);
      default:          phase_last = '0;
    endcase
    phase_done = (div_cnt == phase_last);
    state_nxt  = state;
    case (state)
      IDLE:    if (accept)     state_nxt = SETUP;
      SETUP:   if (phase_done) state_nxt = SCLK_HI;
      SCLK_HI: if (phase_done) state_nxt = last_bit ? HOLD : SCLK_LO;
      SCLK_LO: if (phase_done) state_nxt = SCLK_HI;
      HOLD:    if (phase_done) state_nxt = GAP;
      GAP:     if (phase_done) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // output decode: strobes that update the registered pins and datapath
  always_comb begin
    load      = 1'b0;
    sclk_rise = 1'b0;
    sclk_fall = 1'b0;
    frame_end = 1'b0;
    case (state)
      IDLE:           load      = accept;
      SETUP, SCLK_LO: sclk_rise = phase_done;
      SCLK_HI:        sclk_fall = phase_done;
      HOLD:           frame_end = phase_done;
      default:        ;
    endcase
  end

  // pins are registered so sclk/cs_n never glitch and drop immediately on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miso_meta   <= 1'b0;
      miso_sync   <= 1'b0;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      tx_sh       <= '0;
      rx_sh       <= '0;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
`ifdef SPI_MASTER_PARITY_EN
      rx_par      <= 1'b0;
`endif
    end else begin
      miso_meta   <= bus.miso;
      miso_sync   <= miso_meta;
      rsp_valid_q <= frame_end;
      if (state_nxt != state || state == IDLE) div_cnt <= '0;
      else                                     div_cnt <= div_cnt + DIV_W'(1);

      if (load) begin
        tx_sh   <= frame_word;
        mosi_q  <= frame_word[N_BITS-1];
        cs_n_q  <= 1'b0;
        bit_cnt <= '0;
`ifdef SPI_MASTER_PARITY_EN
        rx_par  <= 1'b0;
`endif
      end
      if (sclk_rise) sclk_q <= 1'b1;
      if (sclk_fall) begin
        sclk_q  <= 1'b0;
        bit_cnt <= bit_cnt + BIT_W'(1);
`ifdef SPI_MASTER_PARITY_EN
        // parity bit is checked, not kept: rx_sh ends up holding the 32 field bits
        rx_par  <= rx_par ^ miso_sync;
        if (!last_bit) rx_sh <= {rx_sh[30:0], miso_sync};
`else
        rx_sh   <= {rx_sh[30:0], miso_sync};
`endif
        if (!last_bit) begin
          mosi_q <= tx_sh[N_BITS-2];
          tx_sh  <= tx_sh << 1;
        end
      end
      if (frame_end) begin
        cs_n_q     <= 1'b1;
        mosi_q     <= 1'b0;
        rsp_data_q <= rx_sh;
`ifdef SPI_MASTER_PARITY_EN
        // XOR over all 41 received bits is zero when the slave parity is right
        rsp_err_q  <= rx_par;
`endif
      end
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.sclk      = sclk_q;
  assign bus.cs_n      = cs_n_q;
  assign bus.mosi      = mosi_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_spi_master_cmd.sv
// tb_spi_master_cmd: self-checking bench for spi_master_cmd with an SPI slave model.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_master_cmd;
  localparam int CLK_DIV      = 4;
  localparam int CS_SETUP_CYC = 2;
  localparam int CS_HOLD_CYC  = 2;
  localparam int CS_GAP_CYC   = 4;
`ifdef SPI_MASTER_PARITY_EN
  localparam int N_BITS = 41;
  localparam bit PAR    = 1'b1;
`else
  localparam int N_BITS = 40;
  localparam bit PAR    = 1'b0;
`endif
  localparam int SETUP_LEN  = (CS_SETUP_CYC > CLK_DIV) ? CS_SETUP_CYC : CLK_DIV;
  // cs_n low: setup phase, then 2*N_BITS half periods minus the first low one, then hold
  localparam int CS_LOW_CYC = SETUP_LEN + (2 * N_BITS - 1) * CLK_DIV + CS_HOLD_CYC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  spi_master_cmd_if bus();

  spi_master_cmd #(
    .CLK_DIV(CLK_DIV), .CS_SETUP_CYC(CS_SETUP_CYC),
    .CS_HOLD_CYC(CS_HOLD_CYC), .CS_GAP_CYC(CS_GAP_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- monitor (samples on the falling clk edge) ----------------
  int          cyc = 0, rise_cnt = 0, fall_cnt = 0, spacing_bad = 0, cs_sclk_bad = 0;
  int          rsp_cnt = 0, frame_rise = 0, last_rise = 0;
  int          cs_fall = 0, cs_rise = 0, cs_low_len = 0, gap_len = 0;
  logic [63:0] mosi_sh = '0;
  logic [31:0] rsp_dat_q = '0;
  logic        rsp_err_q = 1'b0;
  logic        sclk_d = 1'b0, cs_d = 1'b1;

  always @(negedge clk) begin
    cyc    <= cyc + 1;
    sclk_d <= bus.sclk;
    cs_d   <= bus.cs_n;
    if (bus.sclk && !sclk_d) begin
      rise_cnt   <= rise_cnt + 1;
      frame_rise <= frame_rise + 1;
      last_rise  <= cyc;
      mosi_sh    <= {mosi_sh[62:0], bus.mosi};
      if (frame_rise != 0 && (cyc - last_rise) != 2 * CLK_DIV) spacing_bad <= spacing_bad + 1;
    end
    if (!bus.sclk && sclk_d) fall_cnt <= fall_cnt + 1;
    if (bus.cs_n !== cs_d && bus.sclk !== 1'b0) cs_sclk_bad <= cs_sclk_bad + 1;
    if (!bus.cs_n && cs_d) begin
      cs_fall    <= cyc;
      gap_len    <= cyc - cs_rise;
      frame_rise <= 0;
    end
    if (bus.cs_n && !cs_d) begin
      cs_rise    <= cyc;
      cs_low_len <= cyc - cs_fall;
    end
    if (bus.rsp_valid) begin
      rsp_cnt   <= rsp_cnt + 1;
      rsp_dat_q <= bus.rsp_data;
      rsp_err_q <= bus.rsp_err;
    end
  end

  // ---------------- SPI slave model (mode 0, drives after sclk falls) ----------------
  logic [63:0] reply_cur = '0;
  logic [63:0] sl_sh;
  logic        sl_cs_d, sl_sclk_d;

  always @(negedge clk) begin
    sl_cs_d   <= bus.cs_n;
    sl_sclk_d <= bus.sclk;
    if (rst) begin
      bus.miso <= 1'b0;
    end else if (!bus.cs_n && sl_cs_d) begin
      bus.miso <= reply_cur[N_BITS-1];
      sl_sh    <= reply_cur << 1;
    end else if (!bus.cs_n && !bus.sclk && sl_sclk_d) begin
      bus.miso <= sl_sh[N_BITS-1];
      sl_sh    <= sl_sh << 1;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] slave_frame(input logic [39:0] w, input logic bad);
    if (PAR) return {23'b0, w, (^w) ^ bad};
    return {24'b0, w};
  endfunction

  function automatic logic [63:0] exp_mosi(input logic [7:0] op, input logic [31:0] d);
    logic [39:0] f;
    f = {op, d};
    if (PAR) return {23'b0, f, ^f};
    return {24'b0, f};
  endfunction

  function automatic logic [63:0] mosi_frame(input logic [63:0] sh);
    return sh & ((64'd1 << N_BITS) - 64'd1);
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_rsp(input int r0, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (rsp_cnt != r0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check({nm, " rsp_arrived"}, 64'(ok), 64'd1);
  endtask

  task automatic issue(input logic [7:0] op, input logic [31:0] d, input string nm);
    int n = 0;
    while (!bus.cmd_ready && n < 3000) begin
      tick();
      n++;
    end
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = op;
    bus.cmd_data   = d;
    tick();
    check({nm, " accepted_busy"}, 64'(bus.busy), 64'd1);
    bus.cmd_valid  = 1'b0;
    bus.cmd_opcode = 8'($urandom);
    bus.cmd_data   = $urandom;
  endtask

  // one complete frame: issue, wait for the reply, then check everything about it
  task automatic run_cmd(input string nm, input logic [7:0] op, input logic [31:0] d,
                         input logic [39:0] w, input logic bad, input logic [31:0] exp_rsp);
    int r0, ri0, f0, sp0;
    r0 = rsp_cnt; ri0 = rise_cnt; f0 = fall_cnt; sp0 = spacing_bad;
    reply_cur = slave_frame(w, bad);
    issue(op, d, nm);
    wait_rsp(r0, nm);
    check({nm, " rsp_data"}, 64'(rsp_dat_q), 64'(exp_rsp));
    check({nm, " rsp_err"}, 64'(rsp_err_q), 64'(PAR & bad));
    check({nm, " mosi_frame"}, mosi_frame(mosi_sh), exp_mosi(op, d));
    check({nm, " cs_low_cycles"}, 64'(cs_low_len), 64'(CS_LOW_CYC));
    repeat (CS_GAP_CYC + 20) tick();
    check({nm, " rsp_pulses"}, 64'(rsp_cnt - r0), 64'd1);
    check({nm, " sclk_rises"}, 64'(rise_cnt - ri0), 64'(N_BITS));
    check({nm, " sclk_falls"}, 64'(fall_cnt - f0), 64'(N_BITS));
    check({nm, " sclk_spacing_bad"}, 64'(spacing_bad - sp0), 64'd0);
    check({nm, " idle_ready"}, 64'(bus.cmd_ready), 64'd1);
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [31:0] data;
    logic [39:0] word;
    logic        bad;
    logic [31:0] exp_rsp;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int r0, ri0, n;
    logic [7:0]  op;
    logic [31:0] d, exp_b;
    logic [39:0] w;
    logic        bad;

    tbl[0] = '{8'h10, 32'h0000_03E8, 40'h3C_A5A5_5A5A, 1'b0, 32'hA5A5_5A5A};
    tbl[1] = '{8'hFF, 32'hFFFF_FFFF, 40'h00_0000_0000, 1'b0, 32'h0000_0000};
    tbl[2] = '{8'h00, 32'h0000_0000, 40'hFF_FFFF_FFFF, 1'b0, 32'hFFFF_FFFF};
    tbl[3] = '{8'hA5, 32'h1234_5678, 40'h81_8000_0001, 1'b1, 32'h8000_0001};
    tbl[4] = '{8'h5A, 32'hDEAD_BEEF, 40'h7E_CAFE_F00D, 1'b1, 32'hCAFE_F00D};

    bus.cmd_valid  = 1'b0;
    bus.cmd_opcode = '0;
    bus.cmd_data   = '0;

    // reset values
    rst = 1'b1;
    repeat (3) tick();
    check("rst cs_n", 64'(bus.cs_n), 64'd1);
    check("rst sclk", 64'(bus.sclk), 64'd0);
    check("rst mosi", 64'(bus.mosi), 64'd0);
    check("rst cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst rsp_data", 64'(bus.rsp_data), 64'd0);
    check("rst rsp_err", 64'(bus.rsp_err), 64'd0);
    rst = 1'b0;
    repeat (100) tick();
    check("idle cs_n", 64'(bus.cs_n), 64'd1);
    check("idle sclk_rises", 64'(rise_cnt), 64'd0);
    check("idle cmd_ready", 64'(bus.cmd_ready), 64'd1);

    // table vectors
    for (int i = 0; i < 5; i++)
      run_cmd($sformatf("tbl%0d", i), tbl[i].op, tbl[i].data, tbl[i].word, tbl[i].bad, tbl[i].exp_rsp);

    // randomized frames against the model: reply field is the slave word's last 32 bits
    for (int i = 0; i < 8; i++) begin
      op  = 8'($urandom);
      d   = $urandom;
      w   = {8'($urandom), 32'($urandom)};
      bad = 1'($urandom_range(0, 1));
      run_cmd($sformatf("rnd%0d", i), op, d, w, bad, w[31:0]);
    end

    // cmd_valid held high across two frames
    r0 = rsp_cnt; ri0 = rise_cnt;
    reply_cur = slave_frame(40'h11_1357_9BDF, 1'b0);
    bus.cmd_valid = 1'b1; bus.cmd_opcode = 8'h21; bus.cmd_data = 32'h0BAD_F00D;
    tick();
    check("b2b first_busy", 64'(bus.busy), 64'd1);
    bus.cmd_opcode = 8'h42; bus.cmd_data = 32'h7654_3210;
    tick();
    reply_cur = slave_frame(40'h22_2468_ACE0, 1'b0);
    wait_rsp(r0, "b2b A");
    check("b2b A rsp_data", 64'(rsp_dat_q), 64'h1357_9BDF);
    check("b2b A mosi_frame", mosi_frame(mosi_sh), exp_mosi(8'h21, 32'h0BAD_F00D));
    n = 0;
    while (!bus.cmd_ready && n < 100) begin tick(); n++; end
    tick();
    check("b2b second_busy", 64'(bus.busy), 64'd1);
    bus.cmd_valid = 1'b0;
    wait_rsp(r0 + 1, "b2b B");
    check("b2b B rsp_data", 64'(rsp_dat_q), 64'h2468_ACE0);
    check("b2b B mosi_frame", mosi_frame(mosi_sh), exp_mosi(8'h42, 32'h7654_3210));
    check("b2b gap_ok", 64'(gap_len >= CS_GAP_CYC), 64'd1);
    repeat (CS_GAP_CYC + 20) tick();
    check("b2b rsp_pulses", 64'(rsp_cnt - r0), 64'd2);
    check("b2b sclk_rises", 64'(rise_cnt - ri0), 64'(2 * N_BITS));

    // cmd_valid pulsed mid-frame is ignored
    r0 = rsp_cnt; ri0 = rise_cnt;
    reply_cur = slave_frame(40'h5A_0F0F_F0F0, 1'b0);
    issue(8'h33, 32'h0000_0033, "pulse");
    repeat (100) tick();
    bus.cmd_valid = 1'b1; bus.cmd_opcode = 8'h99; bus.cmd_data = 32'h9999_9999;
    repeat (3) tick();
    bus.cmd_valid = 1'b0;
    wait_rsp(r0, "pulse");
    check("pulse rsp_data", 64'(rsp_dat_q), 64'h0F0F_F0F0);
    check("pulse mosi_frame", mosi_frame(mosi_sh), exp_mosi(8'h33, 32'h0000_0033));
    repeat (CS_GAP_CYC + 40) tick();
    check("pulse rsp_pulses", 64'(rsp_cnt - r0), 64'd1);
    check("pulse sclk_rises", 64'(rise_cnt - ri0), 64'(N_BITS));

    // reset asserted at bit 20
    r0 = rsp_cnt; ri0 = rise_cnt;
    reply_cur = slave_frame(40'h00_FFFF_0000, 1'b0);
    issue(8'h44, 32'h4444_4444, "rst_mid");
    n = 0;
    while ((rise_cnt - ri0) < 20 && n < 3000) begin tick(); n++; end
    check("rst_mid sclk_high_before", 64'(bus.sclk), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_mid cs_n", 64'(bus.cs_n), 64'd1);
    check("rst_mid sclk", 64'(bus.sclk), 64'd0);
    check("rst_mid busy", 64'(bus.busy), 64'd0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (20) tick();
    check("rst_mid no_rsp", 64'(rsp_cnt - r0), 64'd0);
    run_cmd("after_rst", 8'h55, 32'hC001_D00D, 40'hAB_89AB_CDEF, 1'b0, 32'h89AB_CDEF);

    check("cs_change_sclk_high", 64'(cs_sclk_bad), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
